// File: rtl/uvmt_cv32e40s_obi_stall_pkg.sv
// Shared types and defaults for the OBI response-latency tracker.
// Status fields are a fixed width so one struct serves any channel parameterisation.
package uvmt_cv32e40s_obi_stall_pkg;

  localparam int unsigned MaxStallsDefault = 8;
  localparam int unsigned DepthDefault     = 8;
  localparam int unsigned StatusW          = 16;

  typedef struct packed {
    logic must_respond;
    logic violation;
    logic violation_sticky;
    logic overflow;
    logic underflow;
  } ch_flags_t;

  typedef struct packed {
    logic [StatusW-1:0] outstanding;
    logic [StatusW-1:0] oldest_lapse;
    logic [StatusW-1:0] budget;
    ch_flags_t          flags;
  } ch_status_t;

  // Modulo increment that works for non-power-of-two depths.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_obi_lapse_queue.sv
// One OBI channel: in-order queue of elapsed-cycle counters, latency budget and sticky flags.
module uvmt_cv32e40s_obi_lapse_queue
  import uvmt_cv32e40s_obi_stall_pkg::*;
#(
  parameter int unsigned DEPTH      = DepthDefault,
  parameter int unsigned MAX_STALLS = MaxStallsDefault,
  parameter int unsigned CNT_W      = $clog2(MAX_STALLS + 2),
  parameter int unsigned OUT_W      = $clog2(DEPTH + 1)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic       i_req,
  input  logic       i_gnt,
  input  logic       i_rvalid,
  output ch_status_t o_status
);

  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LapseMax = CNT_W'(MAX_STALLS);
  localparam logic [CNT_W-1:0] LapseSat = CNT_W'(MAX_STALLS + 1);

  logic [CNT_W-1:0] r_lapse_q [DEPTH];
  logic [CNT_W-1:0] w_lapse_d [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr_q, r_rd_ptr_q, w_wr_ptr_d, w_rd_ptr_d;
  logic [OUT_W-1:0] r_count_q, w_count_d;
  logic             r_viol_sticky_q, r_overflow_q, r_underflow_q;

  logic             w_hs, w_empty, w_full, w_pop, w_push;
  logic             w_ovf_evt, w_unf_evt, w_violation, w_must_respond;
  logic [CNT_W-1:0] w_oldest, w_budget;

  assign w_hs    = i_req & i_gnt;
  assign w_empty = (r_count_q == '0);
  assign w_full  = (r_count_q == OUT_W'(DEPTH));
  assign w_pop   = i_rvalid & ~w_empty;
  // A full queue still accepts a push when the oldest slot is freed in the same cycle.
  assign w_push  = w_hs & (~w_full | w_pop);

  assign w_ovf_evt = w_hs & w_full & ~w_pop;
  assign w_unf_evt = i_rvalid & w_empty;

  assign w_oldest       = w_empty ? '0 : r_lapse_q[r_rd_ptr_q];
  assign w_budget       = (w_oldest >= LapseMax) ? '0 : LapseMax - w_oldest;
  assign w_must_respond = ~w_empty & (w_budget == '0);
  assign w_violation    = i_enable & ~w_empty & ~i_rvalid & (w_oldest > LapseMax);

  always_comb begin
    // Dead slots may age freely; they are overwritten with 1 on the next push.
    for (int i = 0; i < DEPTH; i++) begin
      w_lapse_d[i] = (r_lapse_q[i] == LapseSat) ? r_lapse_q[i] : r_lapse_q[i] + CNT_W'(1);
    end
    if (w_push) begin
      w_lapse_d[r_wr_ptr_q] = CNT_W'(1);
    end
  end

  always_comb begin
    w_wr_ptr_d = w_push ? PtrW'(wrap_inc(32'(r_wr_ptr_q), DEPTH)) : r_wr_ptr_q;
    w_rd_ptr_d = w_pop  ? PtrW'(wrap_inc(32'(r_rd_ptr_q), DEPTH)) : r_rd_ptr_q;
    w_count_d  = r_count_q;
    if (w_push && !w_pop) begin
      w_count_d = r_count_q + OUT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_lapse_q[i] <= '0;
      end
      r_wr_ptr_q      <= '0;
      r_rd_ptr_q      <= '0;
      r_count_q       <= '0;
      r_viol_sticky_q <= 1'b0;
      r_overflow_q    <= 1'b0;
      r_underflow_q   <= 1'b0;
    end else begin
      r_lapse_q       <= w_lapse_d;
      r_wr_ptr_q      <= w_wr_ptr_d;
      r_rd_ptr_q      <= w_rd_ptr_d;
      r_count_q       <= w_count_d;
      // A new event in the clear cycle wins over the clear.
      r_viol_sticky_q <= (r_viol_sticky_q & ~i_clear) | w_violation;
      r_overflow_q    <= (r_overflow_q & ~i_clear) | w_ovf_evt;
      r_underflow_q   <= (r_underflow_q & ~i_clear) | w_unf_evt;
    end
  end

  always_comb begin
    o_status                        = '0;
    o_status.outstanding            = StatusW'(r_count_q);
    o_status.oldest_lapse           = StatusW'(w_oldest);
    o_status.budget                 = StatusW'(w_budget);
    o_status.flags.must_respond     = w_must_respond;
    o_status.flags.violation        = w_violation;
    o_status.flags.violation_sticky = r_viol_sticky_q;
    o_status.flags.overflow         = r_overflow_q;
    o_status.flags.underflow        = r_underflow_q;
  end

endmodule

// File: rtl/uvmt_cv32e40s_obi_stall_tracker.sv
// Multi-channel OBI response-latency tracker: one lapse queue per channel, outputs packed flat.
module uvmt_cv32e40s_obi_stall_tracker
  import uvmt_cv32e40s_obi_stall_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH      = DepthDefault,
  parameter int unsigned MAX_STALLS = MaxStallsDefault,
  parameter int unsigned CNT_W      = $clog2(MAX_STALLS + 2),
  parameter int unsigned OUT_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic [NUM_CH-1:0]       gnt_i,
  input  logic [NUM_CH-1:0]       rvalid_i,
  output logic [NUM_CH*OUT_W-1:0] outstanding_o,
  output logic [NUM_CH*CNT_W-1:0] oldest_lapse_o,
  output logic [NUM_CH*CNT_W-1:0] budget_o,
  output logic [NUM_CH-1:0]       must_respond_o,
  output logic [NUM_CH-1:0]       violation_o,
  output logic [NUM_CH-1:0]       violation_sticky_o,
  output logic [NUM_CH-1:0]       overflow_o,
  output logic [NUM_CH-1:0]       underflow_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_status_t w_status;
    logic       w_status_unused;

    uvmt_cv32e40s_obi_lapse_queue #(
      .DEPTH      (DEPTH),
      .MAX_STALLS (MAX_STALLS),
      .CNT_W      (CNT_W),
      .OUT_W      (OUT_W)
    ) u_lapse_queue (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .i_enable (enable_i),
      .i_clear  (clear_i),
      .i_req    (req_i[c]),
      .i_gnt    (gnt_i[c]),
      .i_rvalid (rvalid_i[c]),
      .o_status (w_status)
    );

    assign outstanding_o[c*OUT_W +: OUT_W]  = w_status.outstanding[OUT_W-1:0];
    assign oldest_lapse_o[c*CNT_W +: CNT_W] = w_status.oldest_lapse[CNT_W-1:0];
    assign budget_o[c*CNT_W +: CNT_W]       = w_status.budget[CNT_W-1:0];
    assign must_respond_o[c]                = w_status.flags.must_respond;
    assign violation_o[c]                   = w_status.flags.violation;
    assign violation_sticky_o[c]            = w_status.flags.violation_sticky;
    assign overflow_o[c]                    = w_status.flags.overflow;
    assign underflow_o[c]                   = w_status.flags.underflow;

    // Upper status bits are zero padding of the fixed-width struct.
    assign w_status_unused = ^{w_status.outstanding[StatusW-1:OUT_W],
                               w_status.oldest_lapse[StatusW-1:CNT_W],
                               w_status.budget[StatusW-1:CNT_W]};
  end

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_stall_tracker.sv
// Scoreboard bench: a timestamp-queue model predicts each cycle's outputs; a monitor compares.
module tb_uvmt_cv32e40s_obi_stall_tracker;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned MAX_STALLS = 8;
  localparam int unsigned CNT_W      = $clog2(MAX_STALLS + 2);
  localparam int unsigned OUT_W      = $clog2(DEPTH + 1);

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    enable_i = 1'b0;
  logic                    clear_i = 1'b0;
  logic [NUM_CH-1:0]       req_i = '0;
  logic [NUM_CH-1:0]       gnt_i = '0;
  logic [NUM_CH-1:0]       rvalid_i = '0;
  logic [NUM_CH*OUT_W-1:0] outstanding_o;
  logic [NUM_CH*CNT_W-1:0] oldest_lapse_o;
  logic [NUM_CH*CNT_W-1:0] budget_o;
  logic [NUM_CH-1:0]       must_respond_o, violation_o, violation_sticky_o;
  logic [NUM_CH-1:0]       overflow_o, underflow_o;

  uvmt_cv32e40s_obi_stall_tracker #(
    .NUM_CH     (NUM_CH),
    .DEPTH      (DEPTH),
    .MAX_STALLS (MAX_STALLS),
    .CNT_W      (CNT_W),
    .OUT_W      (OUT_W)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .enable_i           (enable_i),
    .clear_i            (clear_i),
    .req_i              (req_i),
    .gnt_i              (gnt_i),
    .rvalid_i           (rvalid_i),
    .outstanding_o      (outstanding_o),
    .oldest_lapse_o     (oldest_lapse_o),
    .budget_o           (budget_o),
    .must_respond_o     (must_respond_o),
    .violation_o        (violation_o),
    .violation_sticky_o (violation_sticky_o),
    .overflow_o         (overflow_o),
    .underflow_o        (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NUM_CH*OUT_W-1:0] outst;
    logic [NUM_CH*CNT_W-1:0] lapse;
    logic [NUM_CH*CNT_W-1:0] budget;
    logic [NUM_CH-1:0]       must;
    logic [NUM_CH-1:0]       viol;
    logic [NUM_CH-1:0]       vst;
    logic [NUM_CH-1:0]       ovf;
    logic [NUM_CH-1:0]       unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Model: each channel holds the handshake cycle numbers of its outstanding transactions.
  int m_hs[NUM_CH][$];
  bit m_vs[NUM_CH];
  bit m_ov[NUM_CH];
  bit m_un[NUM_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] gnt,
                      input logic [NUM_CH-1:0] rv, input logic en, input logic clr,
                      input logic rst);
    exp_t e;
    @(posedge clk_i);
    #1;
    req_i    = req;
    gnt_i    = gnt;
    rvalid_i = rv;
    enable_i = en;
    clear_i  = clr;
    rst_ni   = ~rst;
    cyc++;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      int n, l, b;
      bit viol, pop, hs, ovf_evt, unf_evt;
      if (rst) begin
        m_hs[c].delete();
        m_vs[c] = 0;
        m_ov[c] = 0;
        m_un[c] = 0;
      end
      n = m_hs[c].size();
      l = (n == 0) ? 0 : cyc - m_hs[c][0];
      if (l > MAX_STALLS + 1) l = MAX_STALLS + 1;
      b = (l >= MAX_STALLS) ? 0 : MAX_STALLS - l;
      viol = !rst && en && n > 0 && l > MAX_STALLS && !rv[c];
      e.outst[c*OUT_W +: OUT_W]  = OUT_W'(n);
      e.lapse[c*CNT_W +: CNT_W]  = CNT_W'(l);
      e.budget[c*CNT_W +: CNT_W] = CNT_W'(b);
      e.must[c] = (n > 0) && (b == 0);
      e.viol[c] = viol;
      e.vst[c]  = m_vs[c];
      e.ovf[c]  = m_ov[c];
      e.unf[c]  = m_un[c];
      if (!rst) begin
        pop     = rv[c] && n > 0;
        hs      = req[c] && gnt[c];
        ovf_evt = hs && n == DEPTH && !pop;
        unf_evt = rv[c] && n == 0;
        if (pop) void'(m_hs[c].pop_front());
        if (hs && !ovf_evt) m_hs[c].push_back(cyc);
        m_vs[c] = (m_vs[c] && !clr) || viol;
        m_ov[c] = (m_ov[c] && !clr) || ovf_evt;
        m_un[c] = (m_un[c] && !clr) || unf_evt;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic en);
    repeat (n) step('0, '0, '0, en, 1'b0, 1'b0);
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("outstanding", 32'(outstanding_o), 32'(e.outst));
      chk("oldest_lapse", 32'(oldest_lapse_o), 32'(e.lapse));
      chk("budget", 32'(budget_o), 32'(e.budget));
      chk("must_respond", 32'(must_respond_o), 32'(e.must));
      chk("violation", 32'(violation_o), 32'(e.viol));
      chk("violation_sticky", 32'(violation_sticky_o), 32'(e.vst));
      chk("overflow", 32'(overflow_o), 32'(e.ovf));
      chk("underflow", 32'(underflow_o), 32'(e.unf));
    end
  end

  initial begin
    logic [NUM_CH-1:0] rq, gn, rv;
    repeat (3) step('0, '0, '0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Response exactly at the lapse limit.
    step('1, '1, '0, 1'b1, 1'b0, 1'b0);
    idle(7, 1'b1);
    step('0, '0, '1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Missing response: must_respond then violation until rvalid.
    step('1, '1, '0, 1'b1, 1'b0, 1'b0);
    idle(11, 1'b1);
    step('0, '0, '1, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    step('0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);

    // Back-to-back grants with responses from the fourth cycle.
    for (int i = 0; i < 11; i++) begin
      step((i < 8) ? '1 : '0, (i < 8) ? '1 : '0, (i >= 3) ? '1 : '0, 1'b1, 1'b0, 1'b0);
    end
    idle(2, 1'b1);

    // Overflow, then push+pop while full.
    repeat (9) step('1, '1, '0, 1'b0, 1'b0, 1'b0);
    step('1, '1, '1, 1'b0, 1'b0, 1'b0);
    repeat (8) step('0, '0, '1, 1'b0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);

    // Underflow and clear.
    step('0, '0, 2'b01, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    step('0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);

    // Reset with transactions in flight.
    repeat (5) step('1, '1, '0, 1'b1, 1'b0, 1'b0);
    step('1, '1, '1, 1'b1, 1'b0, 1'b1);
    step('0, '0, '0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Long stall with checking disabled.
    step('1, '1, '0, 1'b0, 1'b0, 1'b0);
    idle(12, 1'b0);
    step('0, '0, '1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Randomized traffic, independent per channel, varying response density.
    for (int p = 0; p < 6; p++) begin
      int rvpct;
      rvpct = (p % 3 == 0) ? 10 : ((p % 3 == 1) ? 40 : 75);
      for (int i = 0; i < 500; i++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          rq[c] = ($urandom_range(0, 99) < 60);
          gn[c] = ($urandom_range(0, 99) < 70);
          rv[c] = ($urandom_range(0, 99) < rvpct);
        end
        step(rq, gn, rv, $urandom_range(0, 9) != 0, $urandom_range(0, 31) == 0,
             $urandom_range(0, 399) == 0);
      end
    end
    idle(2, 1'b1);

    repeat (3) @(negedge clk_i);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
